// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: holds the PLL in reset, qualifies a synchronised lock, then
// releases per-domain resets in staggered order; re-sequences on lock loss.
module pll_lock_sequencer #(
  parameter int NUM_CHANNELS        = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked_in,
  output logic                    pll_rst,
  output logic [NUM_CHANNELS-1:0] chan_rst,
  output logic                    all_ready,
  output logic                    relock_event,
  output logic [RETRY_W-1:0]      retry_count,
  output logic                    fail
);

  localparam int REL_LEN = STAGGER_CYCLES * NUM_CHANNELS;
  localparam int RC_W    = $clog2(PLL_RST_CYCLES) + 1;
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int ST_W    = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int RL_W    = $clog2(REL_LEN) + 1;

  localparam logic [RC_W-1:0]    RST_LAST  = RC_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0]    ST_LAST   = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RL_W-1:0]    RL_LAST   = RL_W'(REL_LEN);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  logic [1:0]              sync_q;
  logic                    locked_s;
  logic [2:0]              state_q, state_d;
  logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [ST_W-1:0]         stab_cnt_q, stab_cnt_d;
  logic [RL_W-1:0]         rel_cnt_q, rel_cnt_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
  logic                    relock_q, relock_d;

  // locked_in is asynchronous to refclk; only the second flop is ever observed
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], locked_in};
  end

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RESET: if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // lock takes priority over a timeout landing in the same cycle
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_PLL_RESET;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s)                 state_d = S_WAIT_LOCK;
        else if (stab_cnt_q == ST_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!locked_s) begin
          state_d = S_PLL_RESET;
        end else if (rel_cnt_q == RL_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN:   if (!locked_s) state_d = S_PLL_RESET;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_PLL_RESET;
    endcase

    rst_cnt_d  = (state_q == S_PLL_RESET && state_d == S_PLL_RESET) ? rst_cnt_q + 1'b1 : '0;
    to_cnt_d   = (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) ? to_cnt_q + 1'b1 : '0;
    stab_cnt_d = (state_q == S_STABLE && state_d == S_STABLE) ? stab_cnt_q + 1'b1 : '0;
    rel_cnt_d  = (state_q == S_RELEASE && state_d == S_RELEASE) ? rel_cnt_q + 1'b1 : '0;

    // Resets are registered from the next state so lock loss overrides any release
    chan_rst_d = '1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      chan_rst_d[i] = !((state_d == S_RUN) ||
                        ((state_d == S_RELEASE) &&
                         (int'(rel_cnt_d) >= STAGGER_CYCLES * (i + 1))));
    end

    relock_d = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !locked_s;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PLL_RESET;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stab_cnt_q <= '0;
      rel_cnt_q  <= '0;
      retry_q    <= '0;
      chan_rst_q <= '1;
      relock_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      retry_q    <= retry_d;
      chan_rst_q <= chan_rst_d;
      relock_q   <= relock_d;
    end
  end

  assign pll_rst      = (state_q == S_PLL_RESET) || (state_q == S_FAIL);
  assign all_ready    = (state_q == S_RUN);
  assign fail         = (state_q == S_FAIL);
  assign chan_rst     = chan_rst_q;
  assign relock_event = relock_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal timing checks
// plus random lock waveforms compared every cycle against a phase/elapsed-time model.
module tb_pll_lock_sequencer;
  localparam int NCH = 3, LSC = 8, STG = 4, LTC = 32, PRC = 4, MR = 2;
  localparam int RW = 2;
  localparam int PH_PR = 0, PH_WL = 1, PH_ST = 2, PH_REL = 3, PH_RUN = 4, PH_FL = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           locked_in = 1'b0;
  logic           pll_rst;
  logic [NCH-1:0] chan_rst;
  logic           all_ready;
  logic           relock_event;
  logic [RW-1:0]  retry_count;
  logic           fail;

  int n_chk = 0;
  int n_err = 0;

  // model: current phase, cycles spent in it, retries, synchroniser view of lock
  int cyc = 0;
  int m_ph = PH_PR;
  int m_t = 0;
  int m_retry = 0;
  bit m_relock = 1'b0;
  bit m_s1 = 1'b0, m_s2 = 1'b0;
  int nph;
  bit ls, rl;

  logic [NCH-1:0] e_chan;
  logic           e_pll, e_rdy, e_fail;

  pll_lock_sequencer #(
    .NUM_CHANNELS(NCH), .LOCK_STABLE_CYCLES(LSC), .STAGGER_CYCLES(STG),
    .LOCK_TIMEOUT_CYCLES(LTC), .PLL_RST_CYCLES(PRC), .MAX_RETRIES(MR)
  ) dut (
    .refclk(clk), .rst(rst), .locked_in(locked_in), .pll_rst(pll_rst),
    .chan_rst(chan_rst), .all_ready(all_ready), .relock_event(relock_event),
    .retry_count(retry_count), .fail(fail)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; m_ph = PH_PR; m_t = 0; m_retry = 0;
        m_relock = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
        ls = m_s2;
        nph = m_ph;
        rl = 1'b0;
        case (m_ph)
          PH_PR: if (m_t == PRC - 1) nph = PH_WL;
          PH_WL: begin
            if (ls) nph = PH_ST;
            else if (m_t == LTC - 1) begin
              if (m_retry == MR) nph = PH_FL;
              else begin m_retry = m_retry + 1; nph = PH_PR; end
            end
          end
          PH_ST: begin
            if (!ls) nph = PH_WL;
            else if (m_t == LSC - 1) nph = PH_REL;
          end
          PH_REL: begin
            if (!ls) begin nph = PH_PR; rl = 1'b1; end
            else if (m_t == STG * NCH) begin nph = PH_RUN; m_retry = 0; end
          end
          PH_RUN: if (!ls) begin nph = PH_PR; rl = 1'b1; end
          default: nph = m_ph;
        endcase
        m_t = (nph == m_ph) ? m_t + 1 : 0;
        m_ph = nph;
        m_relock = rl;
        m_s2 = m_s1;
        m_s1 = locked_in;
        cyc = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      e_pll = (m_ph == PH_PR) || (m_ph == PH_FL);
      for (int i = 0; i < NCH; i++)
        e_chan[i] = !((m_ph == PH_RUN) || ((m_ph == PH_REL) && (m_t >= STG * (i + 1))));
      e_rdy  = (m_ph == PH_RUN);
      e_fail = (m_ph == PH_FL);
      n_chk = n_chk + 1;
      if ({pll_rst, chan_rst, all_ready, relock_event, retry_count, fail} !==
          {e_pll, e_chan, e_rdy, m_relock, RW'(m_retry), e_fail}) begin
        n_err = n_err + 1;
        $display("FAIL model cyc=%0d got pll_rst=%b chan_rst=%b all_ready=%b relock=%b retry=%0d fail=%b, expected %b %b %b %b %0d %b",
                 cyc, pll_rst, chan_rst, all_ready, relock_event, retry_count, fail,
                 e_pll, e_chan, e_rdy, m_relock, m_retry, e_fail);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_err = n_err + 1;
      n_chk = n_chk + 1;
      $display("FAIL at_cyc wanted=%0d got=%0d", n, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_chan_rst"}, chan_rst, 3'b111);
    chk({tag, "_all_ready"}, all_ready, 0);
    chk({tag, "_relock"}, relock_event, 0);
    chk({tag, "_retry"}, retry_count, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask

  initial begin
    rst = 1'b1;
    locked_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Normal lock: locked_in high from cycle 10, locked_s at 12, RELEASE at 21
    at_cyc(3);  chk("s1_pll_c3", pll_rst, 1);
    at_cyc(4);  chk("s1_pll_c4", pll_rst, 0);
    at_cyc(10); locked_in = 1'b1;
    at_cyc(24); chk("s1_chan_c24", chan_rst, 3'b111);
    at_cyc(25); chk("s1_chan_c25", chan_rst, 3'b110);
    at_cyc(29); chk("s1_chan_c29", chan_rst, 3'b100);
    at_cyc(33); chk("s1_chan_c33", chan_rst, 3'b000); chk("s1_rdy_c33", all_ready, 0);
    at_cyc(34); chk("s1_rdy_c34", all_ready, 1); chk("s1_retry", retry_count, 0);
    chk("s1_fail", fail, 0);

    // Lock loss in RUN
    at_cyc(40); locked_in = 1'b0;
    at_cyc(42); chk("s2_rdy_c42", all_ready, 1);
    at_cyc(43); chk("s2_relock_c43", relock_event, 1); chk("s2_chan_c43", chan_rst, 3'b111);
    chk("s2_rdy_c43", all_ready, 0); chk("s2_pll_c43", pll_rst, 1);
    at_cyc(44); chk("s2_relock_c44", relock_event, 0);
    at_cyc(46); chk("s2_pll_c46", pll_rst, 1);
    at_cyc(47); chk("s2_pll_c47", pll_rst, 0);
    at_cyc(50); locked_in = 1'b1;
    at_cyc(73); chk("s2_rdy_c73", all_ready, 0);
    at_cyc(74); chk("s2_rdy_c74", all_ready, 1);

    // 3-cycle dropout during STABLE delays RELEASE to cycle 30
    locked_in = 1'b0;
    do_reset();
    at_cyc(10); locked_in = 1'b1;
    at_cyc(16); locked_in = 1'b0;
    at_cyc(19); locked_in = 1'b1; chk("s3_relock_c19", relock_event, 0);
    at_cyc(33); chk("s3_chan_c33", chan_rst, 3'b111);
    at_cyc(34); chk("s3_chan_c34", chan_rst, 3'b110);
    at_cyc(43); chk("s3_rdy_c43", all_ready, 1);

    // No lock: three PLL reset pulses, then terminal FAIL
    locked_in = 1'b0;
    do_reset();
    at_cyc(35);  chk("s4_pll_c35", pll_rst, 0); chk("s4_retry_c35", retry_count, 0);
    at_cyc(36);  chk("s4_pll_c36", pll_rst, 1); chk("s4_retry_c36", retry_count, 1);
    at_cyc(72);  chk("s4_pll_c72", pll_rst, 1); chk("s4_retry_c72", retry_count, 2);
    at_cyc(107); chk("s4_fail_c107", fail, 0); chk("s4_pll_c107", pll_rst, 0);
    at_cyc(108); chk("s4_fail_c108", fail, 1); chk("s4_pll_c108", pll_rst, 1);
    at_cyc(110); locked_in = 1'b1;
    at_cyc(150); chk("s4_fail_c150", fail, 1); chk("s4_pll_c150", pll_rst, 1);
    chk("s4_chan_c150", chan_rst, 3'b111); chk("s4_rdy_c150", all_ready, 0);

    // Asynchronous rst between chan_rst[0] and chan_rst[1] release
    locked_in = 1'b1;
    do_reset();
    at_cyc(18); chk("s5_chan_c18", chan_rst, 3'b110);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("s5_async");
    @(negedge clk);
    rst = 1'b0;
    at_cyc(16); chk("s5_chan_c16", chan_rst, 3'b111);
    at_cyc(17); chk("s5_chan_c17", chan_rst, 3'b110);
    at_cyc(26); chk("s5_rdy_c26", all_ready, 1);

    // locked_s rises exactly on the timeout cycle: lock wins
    locked_in = 1'b0;
    do_reset();
    at_cyc(33); locked_in = 1'b1;
    at_cyc(35); chk("s6_pll_c35", pll_rst, 0);
    at_cyc(36); chk("s6_pll_c36", pll_rst, 0); chk("s6_retry_c36", retry_count, 0);
    at_cyc(47); chk("s6_chan_c47", chan_rst, 3'b111);
    at_cyc(48); chk("s6_chan_c48", chan_rst, 3'b110);

    // Random lock waveforms, model-checked every cycle
    for (int ep = 0; ep < 6; ep++) begin
      locked_in = 1'($urandom_range(0, 1));
      do_reset();
      while (cyc < 520) begin
        int len;
        if (locked_in)
          len = $urandom_range(5, 90);
        else
          len = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 160) : $urandom_range(1, 40);
        repeat (len) @(negedge clk);
        locked_in = ~locked_in;
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
